// File: rtl/reg_bank_pkg.sv
// Shared constants and the bulk-clear state type for the 32x32 register bank
// and the 32:1 word mux it feeds.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = 5;
    localparam int WR_CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_seq.sv
// Bulk-clear sequencer: sweeps clr_idx over every entry once per clr_req,
// asserting clr_we and busy for exactly NREGS cycles.
module reg_bank_clr_seq
    import reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output clr_state_e        state
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // clr_req is only looked at in IDLE, so a pulse mid-sweep never restarts it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NREGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_we  = (state_q == CLEAR);
    assign clr_idx = idx_q;
    assign state   = state_q;

endmodule

// File: rtl/reg_bank_32x32.sv
// 32-entry x 32-bit register bank with one write port, a sequenced bulk clear
// and a saturating write counter; every entry is exposed flop-direct on regs_flat.
module reg_bank_32x32
    import reg_bank_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    input  logic                      clr_req,
    output logic                      busy,
    output logic [DATA_W*NREGS-1:0]   regs_flat,
    output logic [WR_CNT_W-1:0]       wr_count
);

    logic [DATA_W-1:0] mem [NREGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    clr_state_e        clr_state;
    logic              wr_acc;

    reg_bank_clr_seq u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .state   (clr_state)
    );

    // Write handshake: a write transfers on a rising edge where wr_en and
    // wr_ready are both high; wr_en while wr_ready is low is dropped, not held.
    assign wr_ready = (clr_state == IDLE);
    assign wr_acc   = wr_en && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc && !(ZERO_REG != 0 && wr_addr == '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Discarded zero-register writes still count as accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_acc && (wr_count != {WR_CNT_W{1'b1}})) begin
            wr_count <= wr_count + WR_CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[k*DATA_W +: DATA_W] = mem[k];
    end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Directed bench for reg_bank_32x32: an array model of the bank checked every
// cycle, plus hand-computed literal checks for each scenario.
module tb_reg_bank_32x32;
  import reg_bank_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wr_en = 1'b0;
  logic [ADDR_W-1:0]       wr_addr = '0;
  logic [DATA_W-1:0]       wr_data = '0;
  logic                    wr_ready;
  logic                    clr_req = 1'b0;
  logic                    busy;
  logic [DATA_W*NREGS-1:0] regs_flat;
  logic [WR_CNT_W-1:0]     wr_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: bank contents, remaining sweep cycles and accepted-write count.
  logic [DATA_W-1:0] exp_mem [NREGS];
  int sweep_left = 0;
  int exp_count = 0;

  reg_bank_32x32 #(.ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clr_req   (clr_req),
    .busy      (busy),
    .regs_flat (regs_flat),
    .wr_count  (wr_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run exceeded time limit (got timeout, required completion)");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Model: a clear is a 32-cycle sweep from entry 0 upward; writes only land outside a sweep.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) exp_mem[i] <= '0;
      sweep_left <= 0;
      exp_count <= 0;
    end else if (sweep_left > 0) begin
      exp_mem[NREGS - sweep_left] <= '0;
      sweep_left <= sweep_left - 1;
    end else begin
      if (wr_en) begin
        if (wr_addr != 0) exp_mem[wr_addr] <= wr_data;
        if (exp_count < 65535) exp_count <= exp_count + 1;
      end
      if (clr_req) sweep_left <= NREGS;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int bad;
      bad = -1;
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (regs_flat[i*DATA_W +: DATA_W] !== exp_mem[i]) bad = i;
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL model_entry%0d t=%0t: got %h, required %h", bad, $time,
                 regs_flat[bad*DATA_W +: DATA_W], exp_mem[bad]);
      end
      checks++;
      if (busy !== (sweep_left > 0)) begin
        errors++;
        $display("FAIL model_busy t=%0t: got %b, required %b", $time, busy, sweep_left > 0);
      end
      checks++;
      if (wr_ready !== (sweep_left == 0)) begin
        errors++;
        $display("FAIL model_wr_ready t=%0t: got %b, required %b", $time, wr_ready, sweep_left == 0);
      end
      checks++;
      if (wr_count !== WR_CNT_W'(exp_count)) begin
        errors++;
        $display("FAIL model_wr_count t=%0t: got %0d, required %0d", $time, wr_count, exp_count);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic clr);
    @(negedge clk);
    wr_en = we;
    wr_addr = a;
    wr_data = d;
    clr_req = clr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] entry(input int k);
    return regs_flat[k*DATA_W +: DATA_W];
  endfunction

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] last;

    // reset
    repeat (2) @(negedge clk);
    check("reset_flat_nonzero", 32'(|regs_flat), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(wr_count), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);

    // 1: write 100+k to entries 1..31
    for (int k = 1; k < NREGS; k++) begin
      drive(1'b1, ADDR_W'(k), DATA_W'(100 + k), 1'b0);
      idle();
      check("t1_entry", entry(k), DATA_W'(100 + k));
    end
    check("t1_entry0", entry(0), 32'd0);
    check("t1_entry17", entry(17), 32'd117);
    check("t1_count", 32'(wr_count), 32'd31);

    // 2: zero register
    drive(1'b1, '0, 32'hDEADBEEF, 1'b0);
    check("t2_ready", 32'(wr_ready), 32'd1);
    idle();
    check("t2_entry0", entry(0), 32'd0);
    check("t2_count", 32'(wr_count), 32'd32);

    // 3: fill with ones, bulk clear
    for (int k = 0; k < NREGS; k++) drive(1'b1, ADDR_W'(k), 32'hFFFFFFFF, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle();
    n = 0;
    while (busy && n < 40) begin
      if (n == 9) begin
        check("t3_entry8_cleared", entry(8), 32'd0);
        check("t3_entry9_pending", entry(9), 32'hFFFFFFFF);
      end
      n++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 32'(n), 32'd32);
    check("t3_all_zero", 32'(|regs_flat), 32'd0);
    check("t3_count", 32'(wr_count), 32'd64);

    // 4: write during clear is dropped
    drive(1'b1, 5'd7, 32'd99, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    for (int j = 1; j <= 9; j++) idle();
    drive(1'b1, 5'd5, 32'd55, 1'b0);
    check("t4_ready_low", 32'(wr_ready), 32'd0);
    idle();
    wait_not_busy("t4_clear_end");
    check("t4_entry5_dropped", entry(5), 32'd0);
    check("t4_count_dropped", 32'(wr_count), 32'd65);
    drive(1'b1, 5'd5, 32'd55, 1'b0);
    idle();
    check("t4_entry5_retry", entry(5), 32'd55);
    check("t4_count_retry", 32'(wr_count), 32'd66);

    // 5: simultaneous write and clear request
    drive(1'b1, 5'd31, 32'd7, 1'b1);
    idle();
    check("t5_count", 32'(wr_count), 32'd67);
    for (int c = 1; c <= 31; c++) begin
      check("t5_entry31_held", entry(31), 32'd7);
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check("t5_entry31_cleared", entry(31), 32'd0);
    check("t5_busy_done", 32'(busy), 32'd0);

    // 6: asynchronous reset mid-clear
    for (int k = 1; k < 4; k++) drive(1'b1, ADDR_W'(k), 32'h0000_0A00 + k, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    for (int j = 1; j <= 15; j++) idle();
    check("t6_busy_before", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_flat", 32'(|regs_flat), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_ready_after", 32'(wr_ready), 32'd1);
    drive(1'b1, 5'd3, 32'd33, 1'b0);
    idle();
    check("t6_entry3", entry(3), 32'd33);
    check("t6_count", 32'(wr_count), 32'd1);

    // wr_count saturation
    last = '0;
    for (int i = 0; i < 65536; i++) begin
      last = DATA_W'($urandom_range(1, 32'h7FFF_FFFF));
      drive(1'b1, 5'd2, last, 1'b0);
    end
    idle();
    check("sat_count", 32'(wr_count), 32'h0000FFFF);
    check("sat_entry2", entry(2), last);

    idle();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_32x32.md
Name: reg_bank_32x32

Overview:
- 32-entry x 32-bit register bank that sits directly upstream of the 32:1 x 32-bit word mux.
- The bank's flattened output drives mux inputs I0..I31; the mux's 5-bit select picks the read word.
- The bank owns all storage, the single write port, and a sequenced bulk-clear engine. It contains no read muxing.

Parameters:
- DATA_W, 32: word width; the mux fixes it at 32.
- NREGS, 32: number of entries; the mux fixes it at 32.
- ADDR_W, 5: write-address width, equal to log2(NREGS).
- ZERO_REG, 1: when 1, entry 0 is hardwired to zero and writes to it are discarded.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request, qualified by wr_ready.
- wr_addr  in  5  write entry index.
- wr_data  in  32  write data.
- wr_ready  out  1  bank accepts a write this cycle.
- clr_req  in  1  single-cycle pulse that starts a bulk clear.
- busy  out  1  bulk clear in progress.
- regs_flat  out  1024  all entries; bits [32k+31:32k] are entry k and feed mux input Ik.
- wr_count  out  16  number of accepted writes (saturating).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 32 entries = 0.
  - FSM = IDLE, clr_idx = 0.
  - busy = 0, wr_ready = 1 after release, wr_count = 0.
  - Reset mid-clear aborts the clear immediately; all entries read 0 regardless of progress.
- FSM states: IDLE, CLEAR.
- IDLE:
  - wr_ready = 1, busy = 0.
  - Write accepted when wr_en = 1: entry[wr_addr] <= wr_data at the clock edge.
  - The new value appears on regs_flat one cycle after the write cycle, with no bypass.
  - If ZERO_REG = 1 and wr_addr = 0: no storage change, but the write is still counted and still acknowledged.
  - clr_req = 1: go to CLEAR next cycle, clr_idx <= 0.
- CLEAR:
  - busy = 1, wr_ready = 0.
  - Each cycle: entry[clr_idx] <= 0, clr_idx <= clr_idx + 1.
  - When clr_idx = 31, that entry is cleared and the FSM returns to IDLE. busy falls after exactly 32 cycles in CLEAR.
  - wr_en while busy is dropped silently. There is no queue and wr_count does not increment; upstream must hold the request until wr_ready.
  - clr_req while busy is ignored and does not restart the count.
- Simultaneous wr_en and clr_req in IDLE:
  - The write is accepted and counted, and CLEAR starts the next cycle.
  - The written entry is therefore zeroed during the sweep.
- wr_count:
  - Increments by 1 per accepted write and saturates at 16'hFFFF (no wrap).
  - It is not cleared by clr_req; only rst_n clears it.
- Width rules:
  - wr_addr is always in range with NREGS = 32; no out-of-range handling is required.
  - clr_idx is 5 bits; the terminal compare is against NREGS-1.
- Timing: regs_flat is driven purely from flops, with no combinational path from any input, so the mux path is register-to-output only.

Decomposition:
- Shared package reg_bank_pkg holds:
  - DATA_W, NREGS, ADDR_W constants, shared with the mux testbench and the top level.
  - State typedef: IDLE = 1'b0, CLEAR = 1'b1.
  - WR_CNT_W = 16.
- One natural sub-module, reg_bank_clr_seq: the IDLE/CLEAR FSM plus clr_idx counter, outputting busy, clr_we and clr_idx.
- The storage array, write decode and wr_count stay in the parent.

Test Plan:
1. Reset then write: write entry k with value 100+k for k = 1..31 -> the cycle after each write, regs_flat[32k+31:32k] = 100+k; entry 0 = 0; wr_count = 31.
2. Zero register: with ZERO_REG = 1, write addr 0 with 32'hDEADBEEF -> entry 0 stays 0, wr_ready = 1, wr_count increments by 1.
3. Bulk clear: fill all entries with 32'hFFFFFFFF, pulse clr_req -> busy high for exactly 32 cycles; entry k reads 0 from cycle k+2 after the pulse; all entries 0 when busy falls; wr_count unchanged.
4. Write during clear: wr_en with addr 5, data 55 at clear cycle 10 -> dropped, and entry 5 = 0 after the clear. Re-issue the write after busy falls -> entry 5 = 55 and wr_count increments.
5. Simultaneous: wr_en addr 31, data 7 together with clr_req in IDLE -> entry 31 = 7 for cycles 1..31 after the pulse, 0 after the last clear cycle; wr_count increments by 1.
6. Async reset mid-clear: assert rst_n low at clear cycle 15, not aligned to a clock edge -> all entries 0, busy 0 and wr_count 0 immediately; after release, writes accepted on the first edge with wr_ready = 1.
